// File: rtl/instr_fetch_cache.sv
// Direct-mapped instruction cache between the PC and instruction memory; hits return in the same cycle.
// Define ICACHE_STATS_EN to add the hit_cnt_o/miss_cnt_o statistics counters.
module instr_fetch_cache #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int TAG_LSB = OFF_W + IDX_W + 2;

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t             r_state, w_state_next;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag [LINES];
  logic [31:0]        r_data [LINES*LINE_WORDS];
  logic [31:0]        r_base;
  logic [IDX_W-1:0]   r_idx;
  logic [OFF_W:0]     r_cnt;

  logic [OFF_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit, w_start, w_ack, w_last;
  logic               w_unused;

  assign w_off    = addr_i[OFF_W+1:2];
  assign w_idx    = addr_i[TAG_LSB-1:OFF_W+2];
  assign w_tag    = addr_i[31:TAG_LSB];
  assign w_unused = &{1'b0, addr_i[1:0]};

  assign w_hit   = (r_state == S_IDLE) & req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_start = (r_state == S_IDLE) & req_i & ~w_hit & ~flush_i;
  // Acks only count while a request is actually outstanding.
  assign w_ack   = (r_state == S_REFILL) & mem_ack_i & ~flush_i;
  assign w_last  = w_ack & (r_cnt == (OFF_W+1)'(LINE_WORDS - 1));

  assign instr_o    = w_hit ? r_data[{w_idx, w_off}] : 32'h0000_0000;
  assign stall_o    = (r_state == S_REFILL) | (req_i & ~w_hit);
  assign mem_req_o  = (r_state == S_REFILL);
  assign mem_addr_o = r_base + {{(29-OFF_W){1'b0}}, r_cnt, 2'b00};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_next = S_REFILL;
      S_REFILL: if (flush_i || w_last) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_cnt   <= '0;
      r_base  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (flush_i) begin
        r_valid <= '0;
      end else if (w_start) begin
        r_base         <= {addr_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        r_idx          <= w_idx;
        r_cnt          <= '0;
        r_valid[w_idx] <= 1'b0;
      end else if (w_ack) begin
        r_cnt <= r_cnt + (OFF_W+1)'(1);
        if (w_last) r_valid[r_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone guard them.
  always_ff @(posedge clk) begin
    if (w_ack) r_data[{r_idx, r_cnt[OFF_W-1:0]}] <= mem_data_i;
    if (w_last) r_tag[r_idx] <= r_base[31:TAG_LSB];
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit)   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_start) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif
endmodule

// File: tb/tb_instr_fetch_cache.sv
// Directed bench for instr_fetch_cache: cold miss, hits, eviction, ack gaps, flush and reset aborts.
module tb_instr_fetch_cache;
  logic        clk = 1'b0;
  logic        rst, req_i, flush_i, mem_ack_i;
  logic [31:0] addr_i, mem_data_i;
  logic [31:0] instr_o, mem_addr_o;
  logic        stall_o, mem_req_o;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_cache #(.LINE_WORDS(4), .LINES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (addr_i),
    .req_i      (req_i),
    .flush_i    (flush_i),
    .instr_o    (instr_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one line refill; gap idle cycles precede each ack, optionally wobbling addr_i.
  task automatic refill(input logic [31:0] base, input logic [31:0] dbase, input int gap, input bit wobble);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        mem_ack_i = 1'b0;
        if (wobble) addr_i = 32'h0000_0C40 + 32'(g * 4) + 32'(k * 16);
        #1;
        chk("gap_stall", {31'b0, stall_o}, 32'd1);
        chk("gap_addr", mem_addr_o, base + 32'(k * 4));
        tick();
      end
      mem_ack_i  = 1'b1;
      mem_data_i = dbase + 32'(k);
      #1;
      chk("rf_stall", {31'b0, stall_o}, 32'd1);
      chk("rf_req", {31'b0, mem_req_o}, 32'd1);
      chk("rf_addr", mem_addr_o, base + 32'(k * 4));
      chk("rf_instr", instr_o, 32'h0);
      tick();
    end
    mem_ack_i = 1'b0;
    addr_i    = base;
    $display("refill base %h data %h gap %0d done", base, dbase, gap);
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
    addr_i = 32'h0; mem_data_i = 32'h0;
    tick();
    tick();
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_mreq", {31'b0, mem_req_o}, 32'd0);
    rst = 1'b0;

    // Cold miss on 0x40: stall in IDLE, then 4 refill cycles.
    req_i = 1'b1; addr_i = 32'h0000_0040;
    #1;
    chk("cold_stall", {31'b0, stall_o}, 32'd1);
    chk("cold_mreq", {31'b0, mem_req_o}, 32'd0);
    tick();
    refill(32'h40, 32'h1000, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      addr_i = 32'h40 + 32'(k * 4);
      #1;
      chk("hit_instr", instr_o, 32'h1000 + 32'(k));
      chk("hit_stall", {31'b0, stall_o}, 32'd0);
      chk("hit_mreq", {31'b0, mem_req_o}, 32'd0);
      $display("fetch %h -> %h", addr_i, instr_o);
      tick();
    end
`ifdef ICACHE_STATS_EN
    chk("stat_miss", miss_cnt_o, 32'd1);
    chk("stat_hit", hit_cnt_o, 32'd4);
`endif

    // Conflict eviction: 0x440 shares index 4 with 0x40.
    addr_i = 32'h0000_0440;
    #1;
    chk("evict_stall", {31'b0, stall_o}, 32'd1);
    tick();
    refill(32'h440, 32'h2000, 0, 1'b0);
    #1;
    chk("evict_hit", instr_o, 32'h2000);
    chk("evict_hstall", {31'b0, stall_o}, 32'd0);
    tick();
    addr_i = 32'h0000_0040;
    #1;
    chk("remiss_stall", {31'b0, stall_o}, 32'd1);
    tick();

    // Ack every third cycle with addr_i wobbling during refill.
    refill(32'h40, 32'h1000, 2, 1'b1);
    addr_i = 32'h0000_0044;
    #1;
    chk("gap_hit", instr_o, 32'h1001);
    chk("gap_hstall", {31'b0, stall_o}, 32'd0);
    tick();

    // Ack with no request outstanding must be ignored.
    req_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    #1;
    chk("idle_mreq", {31'b0, mem_req_o}, 32'd0);
    chk("idle_stall", {31'b0, stall_o}, 32'd0);
    tick();
    mem_ack_i = 1'b0; req_i = 1'b1; addr_i = 32'h0000_0048;
    #1;
    chk("stray_ack_hit", instr_o, 32'h1002);
    tick();

    // Flush mid-refill on line 0x80 after the second ack.
    addr_i = 32'h0000_0080;
    #1;
    chk("fl_stall", {31'b0, stall_o}, 32'd1);
    tick();
    for (int k = 0; k < 2; k++) begin
      mem_ack_i = 1'b1; mem_data_i = 32'h3000 + 32'(k);
      #1;
      chk("fl_addr", mem_addr_o, 32'h80 + 32'(k * 4));
      tick();
    end
    mem_ack_i = 1'b0; flush_i = 1'b1;
    #1;
    chk("fl_mreq_hold", {31'b0, mem_req_o}, 32'd1);
    tick();
    flush_i = 1'b0; addr_i = 32'h0000_0040;
    #1;
    chk("fl_mreq_drop", {31'b0, mem_req_o}, 32'd0);
    chk("fl_remiss", {31'b0, stall_o}, 32'd1);
    tick();
    refill(32'h40, 32'h1000, 0, 1'b0);
    #1;
    chk("fl_refill_hit", instr_o, 32'h1000);
    tick();

    // Flush in IDLE: current hit still delivers, next cycle misses.
    flush_i = 1'b1; addr_i = 32'h0000_004C;
    #1;
    chk("fli_instr", instr_o, 32'h1003);
    chk("fli_stall", {31'b0, stall_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("fli_miss", {31'b0, stall_o}, 32'd1);
    tick();

    // Reset during refill aborts and leaves the line invalid.
    mem_ack_i = 1'b1; mem_data_i = 32'h4000;
    #1;
    chk("rr_mreq", {31'b0, mem_req_o}, 32'd1);
    tick();
    mem_ack_i = 1'b0; rst = 1'b1; req_i = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rr_mreq_drop", {31'b0, mem_req_o}, 32'd0);
    chk("rr_stall", {31'b0, stall_o}, 32'd0);
    chk("rr_instr", instr_o, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rr_stat_hit", hit_cnt_o, 32'd0);
    chk("rr_stat_miss", miss_cnt_o, 32'd0);
`endif
    req_i = 1'b1;
    #1;
    chk("rr_remiss", {31'b0, stall_o}, 32'd1);
    tick();
    chk("rr_restart_addr", mem_addr_o, 32'h4C & 32'hFFFF_FFF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_cache.md
Name: instr_fetch_cache

Overview:
- Direct-mapped instruction cache; the responder to the program counter's fetch address.
- Sits in IF stage between the PC register and the external instruction memory port.
- On hit, returns the instruction in the same cycle.
- On miss, raises stall_o to freeze the PC and refills one line from memory over a req/ack handshake.

Parameters:
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2).
- LINES, 16, number of lines (power of 2).
- Derived: OFF_W = log2(LINE_WORDS), IDX_W = log2(LINES), TAG_W = 30 − OFF_W − IDX_W.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- addr_i  in  32  fetch address from PC; bits [1:0] ignored.
- req_i  in  1  fetch valid (PC running).
- flush_i  in  1  invalidate all lines.
- instr_o  out  32  fetched instruction.
- stall_o  out  1  freeze PC/IF.
- mem_req_o  out  1  memory word request.
- mem_addr_o  out  32  word address of request, bits [1:0]=0.
- mem_ack_i  in  1  memory word valid this cycle.
- mem_data_i  in  32  memory read data, sampled when mem_ack_i=1.

Behaviour:
- Address split: offset = addr_i[OFF_W+1:2]; index = next IDX_W bits; tag = remaining upper bits.
- Storage: per-line valid bit and tag register; data array LINES×LINE_WORDS×32.
- Reset (rst=1 at posedge): all valid=0, FSM→IDLE, refill counter=0, mem_req_o=0. With req_i=0, instr_o=0 and stall_o=0.
- Hit = req_i & valid[index] & (tag match), evaluated combinationally in IDLE.
- instr_o = data[index][offset] on hit, else 32'h0000_0000 (a NOP).
- FSM states: IDLE, REFILL.
- IDLE, req_i=0: stall_o=0, no memory activity.
- IDLE, hit: stall_o=0, instr_o valid in the same cycle (zero added latency).
- IDLE, req_i & miss: stall_o=1 combinationally.
  - Latch line base (addr_i with offset and byte bits cleared) and index.
  - Clear counter, clear valid[index]; →REFILL.
- REFILL: stall_o=1, mem_req_o=1, mem_addr_o = base + counter×4.
  - On mem_ack_i: write mem_data_i to data[idx][counter], counter++.
  - On the ack of word LINE_WORDS−1: set valid[idx], write tag, →IDLE; mem_req_o drops the next cycle.
  - Without ack: hold all outputs and counter.
- addr_i changes during REFILL are ignored; the latched base is used.
- Miss-to-hit timing with ack every cycle: stall_o high for LINE_WORDS+1 cycles, then hit.
- mem_ack_i while mem_req_o=0 is ignored.
- Memory must present words in ascending order, one per ack.
- flush_i in IDLE: all valid=0 next cycle. The current-cycle hit still delivers.
- flush_i in REFILL: abort; all valid=0, →IDLE, mem_req_o=0 next cycle. A pending fetch re-misses and restarts.
- rst in REFILL: abort as for reset. The partially written line stays invalid.
- flush_i and rst together: rst dominates (same result).
- Counter arithmetic is OFF_W+1 bits wide with no wrap past LINE_WORDS.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, adds ports hit_cnt_o (out, 32) and miss_cnt_o (out, 32).
  - hit_cnt_o increments on each IDLE cycle with hit.
  - miss_cnt_o increments on each IDLE→REFILL transition.
  - Both clear on rst, not on flush_i, and wrap modulo 2^32.
- When undefined, neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset then cold miss: rst 2 cycles, req_i=1, addr_i=0x0000_0040, memory acks every cycle with 0x1000+word.
  - Required: mem_addr_o = 0x40, 0x44, 0x48, 0x4C; stall_o high 5 cycles.
  - Required: next cycle instr_o=0x1000, stall_o=0.
- Hits across the line: after refill, step addr_i 0x40→0x4C.
  - Required: instr_o = 0x1000..0x1003, stall_o=0 every cycle, no mem_req_o.
- Conflict eviction: fetch 0x40, then 0x440 (same index, different tag).
  - Required: the second access misses and refills; re-fetch of 0x40 misses again.
- Ack gaps and address wobble: ack every 3rd cycle and toggle addr_i during REFILL.
  - Required: mem_addr_o follows the latched base only; stall_o high until the 4th ack + 1.
- Flush mid-refill: assert flush_i after 2nd ack.
  - Required: mem_req_o=0 next cycle.
  - Required: a fetch of 0x40 then misses and restarts at mem_addr_o=0x40.
- ICACHE_STATS_EN build: cold miss then 3 hits.
  - Required: miss_cnt_o=1, hit_cnt_o=4 (including the post-refill hit).
  - Required: rst clears both to 0.
